pc_next_unit: RTL and testbench

- Program-counter register and next-PC selector for the 54-instruction MIPS core.
- Directly consumes the 32-bit word-scaled, sign-extended branch offset produced by the 18-bit offset extender and forms the branch target as PC+4+offset.
- Also handles J/JAL, JR/JALR, exception entry and ERET.
- Holds PC under pipeline stall, and buffers any redirect that arrives while stalled until the stall releases.

---
 rtl/pc_next_unit.sv | 180 ++++++++++++++++++
 tb/tb_pc_next_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pc_next_unit.sv
// Program-counter register and next-PC selector: sequential, branch, jump, JR, exception and ERET,
// with stall hold and a one-deep redirect buffer. Optional macro PC_REDIRECT_CNT_EN adds redirect_cnt.
module pc_next_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0040_0004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [2:0]  pc_src,
    input  logic        br_taken,
    input  logic [31:0] imm_ext,
    input  logic [25:0] j_index,
    input  logic [31:0] rs_val,
    input  logic [31:0] epc,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] br_target,
    output logic        redirect,
    output logic        misalign,
`ifdef PC_REDIRECT_CNT_EN
    output logic [31:0] redirect_cnt,
`endif
    output logic        pending
);

    localparam logic [2:0] SRC_BRANCH = 3'd1;
    localparam logic [2:0] SRC_JUMP   = 3'd2;
    localparam logic [2:0] SRC_JR     = 3'd3;
    localparam logic [2:0] SRC_EXC    = 3'd4;
    localparam logic [2:0] SRC_ERET   = 3'd5;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t      r_state, w_state_next;
    logic [31:0] r_pc, w_pc_next;
    logic [31:0] r_pend_tgt, w_pend_tgt_next;
    logic        r_pend_mis, w_pend_mis_next;
    logic        r_redirect, w_redirect_next;
    logic        r_misalign, w_misalign_next;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_target;
    logic [31:0] w_jump_target;
    logic        w_jr_mis;
    logic        w_req;
    logic [31:0] w_target;
    logic        w_is_exc;
    logic        w_is_eret;
    logic        w_is_jr;

    assign w_pc_plus4    = r_pc + 32'd4;
    assign w_br_target   = w_pc_plus4 + imm_ext;
    assign w_jump_target = {w_pc_plus4[31:28], j_index, 2'b00};
    assign w_jr_mis      = (rs_val[1:0] != 2'b00);
    assign w_is_exc      = (pc_src == SRC_EXC);
    assign w_is_eret     = (pc_src == SRC_ERET);
    assign w_is_jr       = (pc_src == SRC_JR);

    // Target select; codes 6/7 fall through to sequential with no request.
    always_comb begin
        w_req    = 1'b0;
        w_target = w_pc_plus4;
        case (pc_src)
            SRC_BRANCH: begin
                if (br_taken) begin
                    w_req    = 1'b1;
                    w_target = w_br_target;
                end
            end
            SRC_JUMP: begin
                w_req    = 1'b1;
                w_target = w_jump_target;
            end
            SRC_JR: begin
                w_req    = 1'b1;
                w_target = w_jr_mis ? EXC_VECTOR : rs_val;
            end
            SRC_EXC: begin
                w_req    = 1'b1;
                w_target = EXC_VECTOR;
            end
            SRC_ERET: begin
                w_req    = 1'b1;
                w_target = epc;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_pend_tgt_next = r_pend_tgt;
        w_pend_mis_next = r_pend_mis;
        w_redirect_next = 1'b0;
        w_misalign_next = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (!stall) begin
                    w_pc_next       = w_req ? w_target : w_pc_plus4;
                    w_redirect_next = w_req;
                    w_misalign_next = w_is_jr && w_jr_mis;
                end else if (w_is_exc) begin
                    w_pc_next       = EXC_VECTOR;
                    w_redirect_next = 1'b1;
                end else if (w_req) begin
                    w_pend_tgt_next = w_target;
                    w_pend_mis_next = w_is_jr && w_jr_mis;
                    w_state_next    = ST_PEND;
                end
            end
            ST_PEND: begin
                // Exceptions discard the buffered redirect regardless of stall.
                if (w_is_exc) begin
                    w_pc_next       = EXC_VECTOR;
                    w_redirect_next = 1'b1;
                    w_pend_tgt_next = 32'd0;
                    w_pend_mis_next = 1'b0;
                    w_state_next    = ST_RUN;
                end else if (stall) begin
                    if (w_is_eret) begin
                        w_pend_tgt_next = epc;
                        w_pend_mis_next = 1'b0;
                    end
                end else begin
                    w_pc_next       = r_pend_tgt;
                    w_redirect_next = 1'b1;
                    w_misalign_next = r_pend_mis;
                    w_pend_mis_next = 1'b0;
                    w_state_next    = ST_RUN;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_pend_tgt <= 32'd0;
            r_pend_mis <= 1'b0;
            r_redirect <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_pend_tgt <= w_pend_tgt_next;
            r_pend_mis <= w_pend_mis_next;
            r_redirect <= w_redirect_next;
            r_misalign <= w_misalign_next;
        end
    end

`ifdef PC_REDIRECT_CNT_EN
    logic [31:0] r_redirect_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_redirect_cnt <= 32'd0;
        end else if (r_redirect && (r_redirect_cnt != 32'hFFFF_FFFF)) begin
            r_redirect_cnt <= r_redirect_cnt + 32'd1;
        end
    end

    assign redirect_cnt = r_redirect_cnt;
`endif

    assign pc        = r_pc;
    assign pc_plus4  = w_pc_plus4;
    assign br_target = w_br_target;
    assign redirect  = r_redirect;
    assign misalign  = r_misalign;
    assign pending   = (r_state == ST_PEND);

endmodule

// File: tb/tb_pc_next_unit.sv
// Table-driven scoreboard bench for pc_next_unit: each vector drives one cycle of inputs and
// queues the expected post-edge PC state, which is popped and compared one time unit after the edge.
module tb_pc_next_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [2:0]  pc_src;
    logic        br_taken;
    logic [31:0] imm_ext;
    logic [25:0] j_index;
    logic [31:0] rs_val;
    logic [31:0] epc;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic        redirect;
    logic        misalign;
    logic        pending;
`ifdef PC_REDIRECT_CNT_EN
    logic [31:0] redirect_cnt;
`endif

    pc_next_unit dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .pc_src    (pc_src),
        .br_taken  (br_taken),
        .imm_ext   (imm_ext),
        .j_index   (j_index),
        .rs_val    (rs_val),
        .epc       (epc),
        .pc        (pc),
        .pc_plus4  (pc_plus4),
        .br_target (br_target),
        .redirect  (redirect),
        .misalign  (misalign),
`ifdef PC_REDIRECT_CNT_EN
        .redirect_cnt (redirect_cnt),
`endif
        .pending   (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        stall;
        logic [2:0]  src;
        logic        bt;
        logic [31:0] imm;
        logic [25:0] jidx;
        logic [31:0] rs;
        logic [31:0] epc;
        logic [31:0] e_pc;
        logic        e_red;
        logic        e_mis;
        logic        e_pend;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    function automatic vec_t mk(string name, logic r, logic s, logic [2:0] src, logic bt,
                                logic [31:0] imm, logic [25:0] jidx, logic [31:0] rs,
                                logic [31:0] ep, logic [31:0] e_pc, logic e_red,
                                logic e_mis, logic e_pend);
        vec_t v;
        v.name = name; v.rst = r; v.stall = s; v.src = src; v.bt = bt; v.imm = imm;
        v.jidx = jidx; v.rs = rs; v.epc = ep; v.e_pc = e_pc; v.e_red = e_red;
        v.e_mis = e_mis; v.e_pend = e_pend;
        return v;
    endfunction

    task automatic chk(string tag, string what, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s.%s: got %h, expected %h", tag, what, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
    task automatic apply(vec_t v);
        vec_t e;
        rst = v.rst; stall = v.stall; pc_src = v.src; br_taken = v.bt;
        imm_ext = v.imm; j_index = v.jidx; rs_val = v.rs; epc = v.epc;
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++; n_mis++;
            $display("FAIL %s.scoreboard: got empty queue, expected an entry", v.name);
        end else begin
            e = sb.pop_front();
            chk(e.name, "pc",        pc,        e.e_pc);
            chk(e.name, "redirect",  {31'd0, redirect}, {31'd0, e.e_red});
            chk(e.name, "misalign",  {31'd0, misalign}, {31'd0, e.e_mis});
            chk(e.name, "pending",   {31'd0, pending},  {31'd0, e.e_pend});
            chk(e.name, "pc_plus4",  pc_plus4,  e.e_pc + 32'd4);
            chk(e.name, "br_target", br_target, e.e_pc + 32'd4 + e.imm);
            $display("txn %-12s src=%0d stall=%0b -> pc=%h red=%0b mis=%0b pend=%0b",
                     e.name, e.src, e.stall, pc, redirect, misalign, pending);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //                name         rst s  src  bt imm            jidx         rs             epc            e_pc           red mis pend
        tbl.push_back(mk("reset1",     1, 0, 3'd0, 0, 32'h0,        26'h0,       32'h0,         32'h0,         32'h0040_0000, 0, 0, 0));
        tbl.push_back(mk("reset2",     1, 0, 3'd0, 0, 32'h0,        26'h0,       32'h0,         32'h0,         32'h0040_0000, 0, 0, 0));
        tbl.push_back(mk("seq1",       0, 0, 3'd0, 0, 32'h0,        26'h0,       32'h0,         32'h0,         32'h0040_0004, 0, 0, 0));
        tbl.push_back(mk("seq2",       0, 0, 3'd0, 0, 32'h0,        26'h0,       32'h0,         32'h0,         32'h0040_0008, 0, 0, 0));
        tbl.push_back(mk("seq3",       0, 0, 3'd0, 0, 32'h0,        26'h0,       32'h0,         32'h0,         32'h0040_000C, 0, 0, 0));
        tbl.push_back(mk("seq4",       0, 0, 3'd0, 0, 32'h0,        26'h0,       32'h0,         32'h0,         32'h0040_0010, 0, 0, 0));
        tbl.push_back(mk("br_taken",   0, 0, 3'd1, 1, 32'hFFFF_FFF8, 26'h0,       32'h0,         32'h0,         32'h0040_000C, 1, 0, 0));
        tbl.push_back(mk("seq5",       0, 0, 3'd0, 0, 32'h0,        26'h0,       32'h0,         32'h0,         32'h0040_0010, 0, 0, 0));
        tbl.push_back(mk("br_untaken", 0, 0, 3'd1, 0, 32'hFFFF_FFF8, 26'h0,       32'h0,         32'h0,         32'h0040_0014, 0, 0, 0));
        tbl.push_back(mk("jump1",      0, 0, 3'd2, 0, 32'h0,        26'h0100008, 32'h0,         32'h0,         32'h0040_0020, 1, 0, 0));
        tbl.push_back(mk("jump2",      0, 0, 3'd2, 0, 32'h0,        26'h0100040, 32'h0,         32'h0,         32'h0040_0100, 1, 0, 0));
        tbl.push_back(mk("jr_misal",   0, 0, 3'd3, 0, 32'h0,        26'h0,       32'h0040_0202, 32'h0,         32'h0040_0004, 1, 1, 0));
        tbl.push_back(mk("jr_ok",      0, 0, 3'd3, 0, 32'h0,        26'h0,       32'h0040_0300, 32'h0,         32'h0040_0300, 1, 0, 0));
        tbl.push_back(mk("eret",       0, 0, 3'd5, 0, 32'h0,        26'h0,       32'h0,         32'h0040_0050, 32'h0040_0050, 1, 0, 0));
        tbl.push_back(mk("exc",        0, 0, 3'd4, 0, 32'h0,        26'h0,       32'h0,         32'h0,         32'h0040_0004, 1, 0, 0));
        tbl.push_back(mk("src6",       0, 0, 3'd6, 1, 32'h40,       26'h0,       32'h0,         32'h0,         32'h0040_0008, 0, 0, 0));
        tbl.push_back(mk("src7",       0, 0, 3'd7, 1, 32'h40,       26'h0,       32'h0,         32'h0,         32'h0040_000C, 0, 0, 0));
        tbl.push_back(mk("stl_jump",   0, 1, 3'd2, 0, 32'h0,        26'h0100080, 32'h0,         32'h0,         32'h0040_000C, 0, 0, 1));
        tbl.push_back(mk("stl_br",     0, 1, 3'd1, 1, 32'h100,      26'h0,       32'h0,         32'h0,         32'h0040_000C, 0, 0, 1));
        tbl.push_back(mk("stl_seq",    0, 1, 3'd0, 0, 32'h0,        26'h0,       32'h0,         32'h0,         32'h0040_000C, 0, 0, 1));
        tbl.push_back(mk("release",    0, 0, 3'd0, 0, 32'h0,        26'h0,       32'h0,         32'h0,         32'h0040_0200, 1, 0, 0));
        tbl.push_back(mk("seq6",       0, 0, 3'd0, 0, 32'h0,        26'h0,       32'h0,         32'h0,         32'h0040_0204, 0, 0, 0));
        tbl.push_back(mk("stl_hold",   0, 1, 3'd0, 0, 32'h0,        26'h0,       32'h0,         32'h0,         32'h0040_0204, 0, 0, 0));
        tbl.push_back(mk("pend_j",     0, 1, 3'd2, 0, 32'h0,        26'h0100100, 32'h0,         32'h0,         32'h0040_0204, 0, 0, 1));
        tbl.push_back(mk("pend_exc",   0, 1, 3'd4, 0, 32'h0,        26'h0,       32'h0,         32'h0,         32'h0040_0004, 1, 0, 0));
        tbl.push_back(mk("after_exc",  0, 0, 3'd0, 0, 32'h0,        26'h0,       32'h0,         32'h0,         32'h0040_0008, 0, 0, 0));
        tbl.push_back(mk("pend_br",    0, 1, 3'd1, 1, 32'h40,       26'h0,       32'h0,         32'h0,         32'h0040_0008, 0, 0, 1));
        tbl.push_back(mk("pend_eret",  0, 1, 3'd5, 0, 32'h0,        26'h0,       32'h0,         32'h0040_0080, 32'h0040_0008, 0, 0, 1));
        tbl.push_back(mk("rel_eret",   0, 0, 3'd2, 0, 32'h0,        26'h0100100, 32'h0,         32'h0,         32'h0040_0080, 1, 0, 0));
        tbl.push_back(mk("stl_exc",    0, 1, 3'd4, 0, 32'h0,        26'h0,       32'h0,         32'h0,         32'h0040_0004, 1, 0, 0));
        tbl.push_back(mk("pend_jr",    0, 1, 3'd3, 0, 32'h0,        26'h0,       32'h0040_0100, 32'h0,         32'h0040_0004, 0, 0, 1));
        tbl.push_back(mk("rel_exc",    0, 0, 3'd4, 0, 32'h0,        26'h0,       32'h0,         32'h0,         32'h0040_0004, 1, 0, 0));
        tbl.push_back(mk("seq7",       0, 0, 3'd0, 0, 32'h0,        26'h0,       32'h0,         32'h0,         32'h0040_0008, 0, 0, 0));
        tbl.push_back(mk("jr_high",    0, 0, 3'd3, 0, 32'h0,        26'h0,       32'h7FFF_FFF8, 32'h0,         32'h7FFF_FFF8, 1, 0, 0));
        tbl.push_back(mk("jump_hi",    0, 0, 3'd2, 0, 32'h0,        26'h0000010, 32'h0,         32'h0,         32'h7000_0040, 1, 0, 0));
        tbl.push_back(mk("jr_top",     0, 0, 3'd3, 0, 32'h0,        26'h0,       32'hFFFF_FFFC, 32'h0,         32'hFFFF_FFFC, 1, 0, 0));
        tbl.push_back(mk("wrap",       0, 0, 3'd0, 0, 32'h0,        26'h0,       32'h0,         32'h0,         32'h0000_0000, 0, 0, 0));
        tbl.push_back(mk("br_zero",    0, 0, 3'd1, 1, 32'h10,       26'h0,       32'h0,         32'h0,         32'h0000_0014, 1, 0, 0));

        foreach (tbl[i]) apply(tbl[i]);

        // Reset while a redirect is buffered: nothing from the old request may leak out.
        apply(mk("rp_stall_j", 0, 1, 3'd2, 0, 32'h0, 26'h0100100, 32'h0, 32'h0, 32'h0000_0014, 0, 0, 1));
        apply(mk("rp_reset",   1, 1, 3'd2, 0, 32'h0, 26'h0100100, 32'h0, 32'h0, 32'h0040_0000, 0, 0, 0));
        apply(mk("rp_after",   0, 0, 3'd0, 0, 32'h0, 26'h0,       32'h0, 32'h0, 32'h0040_0004, 0, 0, 0));

        if (sb.size() != 0) begin
            n_cmp++; n_mis++;
            $display("FAIL scoreboard_drain: got %0d leftover, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
